// File: rtl/and3_gate_core_pkg.sv
// Shared defaults and the saturating-step helper for the 3-input AND core.
package and3_gate_core_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;

    // A counter advances only when asked to and not already pinned at its ceiling.
    function automatic logic sat_step(input logic inc, input logic at_max);
        return inc & ~at_max;
    endfunction

endpackage

// File: rtl/and3_gate_core_sat_counter.sv
// Saturating up-counter, 1-cycle update, synchronous active-high clear.
// No backpressure: inc is sampled every edge and held at all-ones once full.
module and3_gate_core_sat_counter
    import and3_gate_core_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == {CNT_W{1'b1}});

    always_comb begin
        cnt_d = cnt_q;
        if (sat_step(inc, at_max)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/and3_gate_core.sv
// Bitwise 3-input AND (zero latency) plus a 1-cycle registered copy and a
// saturating count of cycles with lane 0 high; no backpressure.
module and3_gate_core
    import and3_gate_core_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [WIDTH-1:0] y_q_q;
    logic [WIDTH-1:0] y_q_d;

    // Kept free of clk/rst so glue logic sees it before any clock edge.
    assign y = a & b & c;

    assign y_q_d = y;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_q <= '0;
        end else begin
            y_q_q <= y_q_d;
        end
    end

    assign y_q = y_q_q;

    and3_gate_core_sat_counter #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (y[0]),
        .cnt (hit_cnt)
    );

endmodule

// File: tb/tb_and3_gate_core.sv
// Directed and randomized checks of and3_gate_core at three parameter points.
module tb_and3_gate_core;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       a, b, c;
    logic [3:0] wa, wb, wc;

    logic        y, y_q;
    logic [15:0] hit_cnt;
    logic        y_s, y_q_s;
    logic [1:0]  hit_cnt_s;
    logic [3:0]  wy, wy_q;
    logic [7:0]  w_cnt;

    int total;
    int bad;

    // Reference state, kept as plain integers.
    int m_yq;
    int m_wyq;
    int m_c16;
    int m_c2;
    int m_c8;

    and3_gate_core #(.WIDTH(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .y(y), .y_q(y_q), .hit_cnt(hit_cnt)
    );

    and3_gate_core #(.WIDTH(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .y(y_s), .y_q(y_q_s), .hit_cnt(hit_cnt_s)
    );

    and3_gate_core #(.WIDTH(4), .CNT_W(8)) dut_w (
        .clk(clk), .rst(rst), .a(wa), .b(wb), .c(wc),
        .y(wy), .y_q(wy_q), .hit_cnt(w_cnt)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    // A lane is high exactly when all three of its input bits are high.
    function automatic int ref_and(input int x, input int yv, input int z, input int width);
        int r;
        r = 0;
        for (int i = 0; i < width; i++) begin
            if (((x >> i) & 1) + ((yv >> i) & 1) + ((z >> i) & 1) == 3) begin
                r += (1 << i);
            end
        end
        return r;
    endfunction

    function automatic int sat_add(input int v, input int maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge; the model absorbs the inputs present at that edge.
    task automatic tick();
        int h;
        int wh;
        @(posedge clk);
        if (rst) begin
            m_yq = 0; m_wyq = 0; m_c16 = 0; m_c2 = 0; m_c8 = 0;
        end else begin
            h  = ref_and(int'(a), int'(b), int'(c), 1);
            wh = ref_and(int'(wa), int'(wb), int'(wc), 4);
            m_yq  = h;
            m_wyq = wh;
            if (h == 1) begin
                m_c16 = sat_add(m_c16, 65535);
                m_c2  = sat_add(m_c2, 3);
            end
            if ((wh & 1) == 1) m_c8 = sat_add(m_c8, 255);
        end
        #1;
    endtask

    initial begin
        logic [2:0]  abc;
        logic [31:0] xexp;
        total  = 0;
        bad    = 0;
        clk_en = 1'b0;
        rst    = 1'b0;
        a = 1'b0; b = 1'b0; c = 1'b0;
        wa = 4'h0; wb = 4'h0; wc = 4'h0;
        m_yq = 0; m_wyq = 0; m_c16 = 0; m_c2 = 0; m_c8 = 0;

        // Exhaustive truth table, no clock running yet.
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            {a, b, c} = abc;
            #10;
            chk($sformatf("comb_%0d", i), 32'(y), (i == 7) ? 32'd1 : 32'd0);
        end

        {a, b, c} = 3'b110; #10; chk("zero_c", 32'(y), 32'd0);
        {a, b, c} = 3'b011; #10; chk("zero_a", 32'(y), 32'd0);
        {a, b, c} = 3'b101; #10; chk("zero_b", 32'(y), 32'd0);

        xexp = 32'd0;
        xexp[0] = 1'bx;
        a = 1'bx; b = 1'b1; c = 1'b1; #10; chk("x_prop", 32'(y), xexp);
        a = 1'bx; b = 1'b0; c = 1'b1; #10; chk("x_mask", 32'(y), 32'd0);

        wa = 4'b1111; wb = 4'b1010; wc = 4'b0110; #10;
        chk("w4_and", 32'(wy), 32'h2);

        // Reset for two edges.
        clk_en = 1'b1;
        a = 1'b1; b = 1'b1; c = 1'b1;
        rst = 1'b1;
        tick(); tick();
        chk("rst_yq",  32'(y_q), 32'd0);
        chk("rst_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_y",   32'(y), 32'd1);
        rst = 1'b0;

        tick();
        chk("yq_after_111", 32'(y_q), 32'd1);
        tick(); tick();
        chk("cnt_after_3", 32'(hit_cnt), 32'd3);
        {a, b, c} = 3'b011;
        tick();
        chk("yq_after_011", 32'(y_q), 32'd0);
        chk("cnt_hold",     32'(hit_cnt), 32'd3);

        // Saturation at CNT_W=2.
        rst = 1'b1; tick(); rst = 1'b0;
        {a, b, c} = 3'b111;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("sat_%0d", k), 32'(hit_cnt_s), (k < 3) ? 32'(k) : 32'd3);
        end

        // Reset beats the increment while y stays high.
        rst = 1'b1;
        #1; chk("prio_y_pre", 32'(y), 32'd1);
        tick();
        chk("prio_yq",   32'(y_q), 32'd0);
        chk("prio_cnt",  32'(hit_cnt), 32'd0);
        chk("prio_cnt2", 32'(hit_cnt_s), 32'd0);
        chk("prio_y",    32'(y), 32'd1);
        rst = 1'b0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 15) == 0);
            a   = ($urandom_range(0, 3) != 0);
            b   = ($urandom_range(0, 3) != 0);
            c   = ($urandom_range(0, 3) != 0);
            wa  = 4'($urandom_range(0, 15));
            wb  = 4'($urandom_range(0, 15));
            wc  = 4'($urandom_range(0, 15));
            #1;
            chk("rnd_y",  32'(y),  32'(ref_and(int'(a), int'(b), int'(c), 1)));
            chk("rnd_ys", 32'(y_s), 32'(ref_and(int'(a), int'(b), int'(c), 1)));
            chk("rnd_wy", 32'(wy), 32'(ref_and(int'(wa), int'(wb), int'(wc), 4)));
            tick();
            chk("rnd_yq",   32'(y_q),       32'(m_yq));
            chk("rnd_yqs",  32'(y_q_s),     32'(m_yq));
            chk("rnd_wyq",  32'(wy_q),      32'(m_wyq));
            chk("rnd_c16",  32'(hit_cnt),   32'(m_c16));
            chk("rnd_c2",   32'(hit_cnt_s), 32'(m_c2));
            chk("rnd_c8",   32'(w_cnt),     32'(m_c8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
